acc_drain_fp16: RTL and testbench

Output drain stage directly downstream of the N×N FP-INT systolic array. On the array's `done` pulse it snapshots every PE's accumulator and exponent. It then converts each one to IEEE FP16 with round-to-nearest-even. The results leave one at a time, row-major, on a valid/ready stream toward the output buffer.

---
 rtl/fp16_pkg.sv | 26 ++
 rtl/fx2fp16_norm.sv | 72 +++++++
 rtl/acc_drain_fp16.sv | 180 ++++++++++++++++++
 tb/tb_acc_drain_fp16.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
// Shared constants and types for the accumulator drain path that turns
// fixed-point PE accumulators into IEEE FP16 words.
//   FP16_*          : field widths, bias and special encodings of FP16
//   drain_state_e   : drain FSM states (capture -> convert -> normalise -> emit)
// -----------------------------------------------------------------------------
package fp16_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_MANT_W  = 10;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_EXP_MAX = 31;

    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_NORM = 2'd2,
        ST_EMIT = 2'd3
    } drain_state_e;

endpackage

// File: rtl/fx2fp16_norm.sv
// -----------------------------------------------------------------------------
// fx2fp16_norm
// Combinational fixed-point to FP16 normaliser with round-to-nearest-even.
// No subnormals: results below the normal range flush to signed zero,
// results at or above the top exponent saturate to signed infinity.
//   sign   : sign of the original accumulator
//   mag    : magnitude, one bit wider than the accumulator
//   p      : position of the leading one in mag (ignored when mag is zero)
//   exp    : PE exponent, same bias as FP16
//   result : rounded FP16 word
// -----------------------------------------------------------------------------
module fx2fp16_norm
    import fp16_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int EXP_WIDTH = 5
) (
    input  logic                           sign,
    input  logic [ACC_WIDTH:0]             mag,
    input  logic [$clog2(ACC_WIDTH+1)-1:0] p,
    input  logic [EXP_WIDTH-1:0]           exp,
    output logic [15:0]                    result
);

    localparam int MAG_W       = ACC_WIDTH + 1;
    localparam int POS_W       = $clog2(MAG_W);
    // Signed working width wide enough for p, exp and the negative offset.
    localparam int EW          = EXP_WIDTH + 7;
    // PE exponents carry the FP16 bias, so re-biasing cancels; kept explicit
    // so a future PE bias change only touches this line.
    localparam int PE_EXP_BIAS = FP16_BIAS;
    localparam int E_ADJ       = FP16_BIAS - PE_EXP_BIAS - FRAC_BITS;

    logic [MAG_W-1:0]        norm_s;
    logic [FP16_MANT_W-1:0]  mant_s;
    logic                    guard_s;
    logic                    sticky_s;
    logic                    round_up_s;
    logic [FP16_MANT_W:0]    mant_rnd_s;
    logic signed [EW-1:0]    e_raw_s;
    logic signed [EW-1:0]    e_rnd_s;

    // Left-justify so the leading one lands in the MSB; zero input stays zero,
    // which makes the MSB double as the non-zero flag.
    assign norm_s     = mag << (POS_W'(MAG_W - 1) - p);
    assign mant_s     = norm_s[MAG_W-2 -: FP16_MANT_W];
    assign guard_s    = norm_s[MAG_W-2-FP16_MANT_W];
    assign sticky_s   = |norm_s[MAG_W-3-FP16_MANT_W:0];
    assign round_up_s = guard_s & (sticky_s | mant_s[0]);
    // Carry-out of the rounded mantissa bumps the exponent; the mantissa
    // field is then all zeros, which the low bits already hold.
    assign mant_rnd_s = {1'b0, mant_s} + {{FP16_MANT_W{1'b0}}, round_up_s};

    assign e_raw_s = $signed(EW'(p)) + $signed(EW'(exp)) + $signed(EW'(E_ADJ));
    assign e_rnd_s = e_raw_s + $signed(EW'(mant_rnd_s[FP16_MANT_W]));

    // Pack the result and apply zero / overflow / flush special cases.
    always_comb begin
        result = FP16_POS_ZERO;
        if (!norm_s[MAG_W-1]) begin
            result = FP16_POS_ZERO;
        end else if (e_rnd_s >= $signed(EW'(FP16_EXP_MAX))) begin
            result = sign ? FP16_NEG_INF : FP16_POS_INF;
        end else if (e_rnd_s <= $signed(EW'(0))) begin
            result = {sign, 15'h0000};
        end else begin
            result = {sign, e_rnd_s[FP16_EXP_W-1:0], mant_rnd_s[FP16_MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/acc_drain_fp16.sv
// -----------------------------------------------------------------------------
// acc_drain_fp16
// Drain stage behind the N x N systolic array. A rising edge of done (while
// idle) snapshots every PE accumulator and exponent; each entry is then
// converted to FP16 and streamed out row-major on a valid/ready interface.
//   clk, rst   : clock, asynchronous active-high reset
//   done       : array frame-complete level, rising edge triggers capture
//   acc_in     : flattened accumulators, PE[r][c] at slice r*N+c
//   exp_in     : flattened exponents, same indexing
//   out_valid  : out_data/out_idx/out_last hold a result
//   out_ready  : consumer accepts the current result
//   out_data   : FP16 result
//   out_idx    : PE index of out_data
//   out_last   : final element of the frame
//   busy       : a frame is held or draining
//   overrun    : sticky, done edge seen while busy
// Per element: CONV (sign, magnitude, leading one) -> NORM (FP16 word) ->
// EMIT (hold until handshake).
// -----------------------------------------------------------------------------
module acc_drain_fp16
    import fp16_pkg::*;
#(
    parameter int N         = 2,
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 10,
    parameter int EXP_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    input  logic [N*N*ACC_WIDTH-1:0]     acc_in,
    input  logic [N*N*EXP_WIDTH-1:0]     exp_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_data,
    output logic [$clog2(N*N)-1:0]       out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int NUM_PE = N * N;
    localparam int IDX_W  = $clog2(NUM_PE);
    localparam int MAG_W  = ACC_WIDTH + 1;
    localparam int POS_W  = $clog2(MAG_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    drain_state_e          state_r;
    logic                  done_q_r;
    logic [ACC_WIDTH-1:0]  acc_snap_r [NUM_PE];
    logic [EXP_WIDTH-1:0]  exp_snap_r [NUM_PE];
    logic [IDX_W-1:0]      idx_r;
    logic                  sign_r;
    logic [MAG_W-1:0]      mag_r;
    logic [POS_W-1:0]      pos_r;

    logic [ACC_WIDTH-1:0]  acc_cur_s;
    logic [EXP_WIDTH-1:0]  exp_cur_s;
    logic                  sign_cur_s;
    logic [MAG_W-1:0]      mag_cur_s;
    logic                  done_rise_s;
    logic                  capture_s;
    logic                  hs_s;
    logic [15:0]           fp_s;

    // Highest set bit of the magnitude; zero input returns 0.
    function automatic logic [POS_W-1:0] lead_one_pos(input logic [MAG_W-1:0] v);
        logic [POS_W-1:0] pos;
        pos = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (v[i]) begin
                pos = POS_W'(i);
            end
        end
        return pos;
    endfunction

    assign acc_cur_s   = acc_snap_r[idx_r];
    assign exp_cur_s   = exp_snap_r[idx_r];
    assign sign_cur_s  = acc_cur_s[ACC_WIDTH-1];
    // One extra bit so the most negative accumulator has an exact magnitude.
    assign mag_cur_s   = sign_cur_s ? ((~{1'b1, acc_cur_s}) + MAG_W'(1))
                                    : {1'b0, acc_cur_s};
    assign done_rise_s = done & ~done_q_r;
    assign capture_s   = done_rise_s & ~busy;
    assign hs_s        = out_valid & out_ready;

    // Edge detector and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q_r <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done_q_r <= done;
            if (done_rise_s && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    // Snapshot register file; contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            for (int k = 0; k < NUM_PE; k++) begin
                acc_snap_r[k] <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
                exp_snap_r[k] <= exp_in[k*EXP_WIDTH +: EXP_WIDTH];
            end
        end
    end

    // Drain FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
            out_idx   <= '0;
            out_last  <= 1'b0;
            sign_r    <= 1'b0;
            mag_r     <= '0;
            pos_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_s) begin
                        idx_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    sign_r  <= sign_cur_s;
                    mag_r   <= mag_cur_s;
                    pos_r   <= lead_one_pos(mag_cur_s);
                    state_r <= ST_NORM;
                end
                ST_NORM: begin
                    out_data  <= fp_s;
                    out_idx   <= idx_r;
                    out_last  <= (idx_r == LAST_IDX);
                    out_valid <= 1'b1;
                    state_r   <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (hs_s) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            busy     <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            state_r <= ST_CONV;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    fx2fp16_norm #(
        .ACC_WIDTH (ACC_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .EXP_WIDTH (EXP_WIDTH)
    ) u_norm (
        .sign   (sign_r),
        .mag    (mag_r),
        .p      (pos_r),
        .exp    (exp_cur_s),
        .result (fp_s)
    );

endmodule

// File: tb/tb_acc_drain_fp16.sv
// -----------------------------------------------------------------------------
// tb_acc_drain_fp16
// Directed bench for acc_drain_fp16 (N=2). Expected FP16 words are hand-derived
// constants pushed to a scoreboard when a frame is loaded and popped on every
// handshake.
// -----------------------------------------------------------------------------
module tb_acc_drain_fp16;

    logic         clk;
    logic         rst;
    logic         done;
    logic [127:0] acc_in;
    logic [19:0]  exp_in;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         busy;
    logic         overrun;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    acc_drain_fp16 #(
        .N         (2),
        .ACC_WIDTH (32),
        .FRAC_BITS (10),
        .EXP_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .acc_in    (acc_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [1:0] idx);
        exp_t e;
        e.data = d;
        e.idx  = idx;
        e.last = (idx == 2'd3);
        sb_q.push_back(e);
    endtask

    task automatic load_frame(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [4:0] e0, input logic [4:0] e1,
                              input logic [4:0] e2, input logic [4:0] e3,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input logic [15:0] d3);
        acc_in = {a3, a2, a1, a0};
        exp_in = {e3, e2, e1, e0};
        push_exp(d0, 2'd0);
        push_exp(d1, 2'd1);
        push_exp(d2, 2'd2);
        push_exp(d3, 2'd3);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    // Accept 'count' results, optionally stalling 10 cycles on stall_idx.
    task automatic drain_frame(input int count, input int stall_idx);
        int          got;
        int          waited;
        bit          stalled;
        exp_t        e;
        logic [15:0] hold_d;
        logic [1:0]  hold_i;
        got     = 0;
        waited  = 0;
        stalled = 1'b0;
        while (got < count && waited < 200) begin
            if (out_valid === 1'b1) begin
                if (!stalled && int'(out_idx) == stall_idx) begin
                    stalled   = 1'b1;
                    hold_d    = out_data;
                    hold_i    = out_idx;
                    out_ready = 1'b0;
                    for (int k = 0; k < 10; k++) begin
                        step();
                        chk("stall_valid", 32'(out_valid), 32'd1);
                        chk("stall_data", 32'(out_data), 32'(hold_d));
                        chk("stall_idx", 32'(out_idx), 32'(hold_i));
                    end
                    out_ready = 1'b1;
                end
                chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_idx", 32'(out_idx), 32'(e.idx));
                    chk("out_last", 32'(out_last), 32'(e.last));
                end
                got++;
            end
            step();
            waited++;
        end
        chk("drain_count", 32'(got), 32'(count));
    endtask

    initial begin
        rst       = 1'b1;
        done      = 1'b0;
        out_ready = 1'b1;
        acc_in    = '0;
        exp_in    = '0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        step();

        // Nominal frame: -28, -28, -21, -21, with latency check.
        load_frame(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00,
                   5'd15, 5'd15, 5'd15, 5'd15,
                   16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40);
        pulse_done();
        chk("busy_t1", 32'(busy), 32'd1);
        chk("valid_t1", 32'(out_valid), 32'd0);
        step();
        chk("valid_t2", 32'(out_valid), 32'd0);
        step();
        chk("valid_t3", 32'(out_valid), 32'd1);
        drain_frame(4, -1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(out_valid), 32'd0);

        // Specials: zero, 1.0, most negative (overflow), flush to zero.
        load_frame(32'h00000000, 32'h00000400, 32'h80000000, 32'h00000001,
                   5'd15, 5'd15, 5'd15, 5'd1,
                   16'h0000, 16'h3C00, 16'hFC00, 16'h0000);
        pulse_done();
        drain_frame(4, -1);

        // Rounding: exact, tie->even stays, tie->odd rounds up, sticky up.
        // 0xC01 = 3 + 2^-10 is a halfway case and rounds down to 3.0.
        load_frame(32'h00000C02, 32'h00000C01, 32'h00200C00, 32'h00200401,
                   5'd15, 5'd15, 5'd15, 5'd15,
                   16'h4201, 16'h4200, 16'h6802, 16'h6801);
        pulse_done();
        drain_frame(4, -1);

        // Mantissa carry, carry into inf, max finite; backpressure on idx 1.
        load_frame(32'h00100200, 32'h00000FFF, 32'h00000FFF, 32'h00000FFE,
                   5'd15, 5'd15, 5'd29, 5'd29,
                   16'h6400, 16'h4400, 16'h7C00, 16'h7BFF);
        pulse_done();
        drain_frame(4, 1);
        chk("busy_after_stall", 32'(busy), 32'd0);

        // Overrun: second done edge with different data while busy.
        load_frame(32'hFFFFFC00, 32'h00000400, 32'h00000001, 32'hFFFFFC00,
                   5'd15, 5'd16, 5'd25, 5'd0,
                   16'hBC00, 16'h4000, 16'h3C00, 16'h8000);
        pulse_done();
        chk("ovr_clear", 32'(overrun), 32'd0);
        step();
        acc_in = {4{32'h00000400}};
        exp_in = {4{5'd15}};
        pulse_done();
        chk("ovr_set", 32'(overrun), 32'd1);
        drain_frame(4, -1);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset after idx 1 is accepted.
        load_frame(32'hFFFF9000, 32'hFFFF9000, 32'hFFFFAC00, 32'hFFFFAC00,
                   5'd15, 5'd15, 5'd15, 5'd15,
                   16'hCF00, 16'hCF00, 16'hCD40, 16'hCD40);
        pulse_done();
        drain_frame(2, -1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_idx", 32'(out_idx), 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        sb_q.delete();
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        // Fresh frame restarts at idx 0: smallest normal, 1.0, -inf, zero.
        load_frame(32'h00000400, 32'h00000400, 32'h80000000, 32'h00000000,
                   5'd1, 5'd15, 5'd15, 5'd0,
                   16'h0400, 16'h3C00, 16'hFC00, 16'h0000);
        pulse_done();
        drain_frame(4, -1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
